status_value_ctrl: RTL and testbench
====================================

# status_value_ctrl

Occupancy and strobe controller placed directly upstream of the per-entry status value update logic in the status valid vector. It accepts raw push/pull/set requests, qualifies them against the vector's occupancy, and drives the qualified strobes plus the per-entry valid, carry and last masks that each entry's update logic consumes. It owns the only sequential occupancy state of the vector: the thermometer valid mask, the entry count, the full/empty flags and the sticky error flags.

## Interface
- DEPTH, 8, number of vector entries; legal range 2..64
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; do not override)

- clk_i  input  1  clock; all state changes on its rising edge
- arst_i  input  1  asynchronous active-high reset
- flush_i  input  1  synchronous clear of all occupancy; highest priority
- push_i  input  1  request to enqueue a new entry at the tail
- pull_i  input  1  request to dequeue the head entry (entry 0)
- set_i  input  1  request to overwrite the current last entry with the set value
- clr_err_i  input  1  clears the sticky error flags
- push_o  output  1  qualified push strobe to the entry logic
- pull_o  output  1  qualified pull strobe to the entry logic
- set_o  output  1  qualified set strobe to the entry logic
- update_o  output  1  update enable to the entry logic; equals push_o
- valid_o  output  DEPTH  thermometer occupancy mask; bit i set when entry i holds data
- carry_o  output  DEPTH  bit i equals valid_o[i+1]; bit DEPTH-1 is 0
- last_o  output  DEPTH  bit i equals valid_o[i+2]; top two bits are 0
- empty_o  output  1  no entries held
- full_o  output  1  all DEPTH entries held
- count_o  output  CNT_W  number of entries held
- err_ovf_o  output  1  sticky: push_i rejected
- err_udf_o  output  1  sticky: pull_i or set_i rejected

## Operation
- State: valid mask register (DEPTH bits), count register (CNT_W bits), err_ovf, err_udf.
- Qualification (combinational from the inputs and current state):
  - pull_o = pull_i & ~empty_o & ~flush_i.
  - push_o = push_i & ~flush_i & (~full_o | pull_o). A push into a full vector is accepted only together with an accepted pull.
  - set_o = set_i & ~empty_o & ~flush_i. Set while empty is rejected.
  - With these rules the entry logic never sees the pull+push case with an empty vector.
- Next state by {pull_o, push_o}:
  - 00: hold.
  - 01: valid <= {valid[DEPTH-2:0],1'b1}; count <= count+1.
  - 10: valid <= valid >> 1; count <= count-1.
  - 11: valid and count hold.
- set_o never changes occupancy.
- flush_i: valid <= 0, count <= 0. All strobes are forced to 0 in that cycle. Error flags are not affected.
- Errors:
  - err_ovf sets on push_i & ~push_o & ~flush_i.
  - err_udf sets on (pull_i | set_i) & empty_o & ~flush_i.
  - clr_err_i clears both. If a set condition and clr_err_i occur in the same cycle, set wins.
- Derived outputs (combinational from registers only):
  - empty_o = ~valid[0]; full_o = valid[DEPTH-1].
  - carry_o = valid >> 1; last_o = valid >> 2.
- Invariant: valid is always a contiguous thermometer code from bit 0, and popcount(valid) == count.

## Timing
- Reset (asynchronous assert): valid 0, count 0, err flags 0. Resulting outputs: empty_o 1, full_o 0, carry_o 0, last_o 0, count_o 0, all strobes 0 while no requests are present. Reset is released synchronously to clk_i by the system.
- Strobes are zero-latency: they are valid in the same cycle as the requests and sampled by the entry registers at the same edge as this block's state.
- Occupancy outputs reflect accepted operations one cycle after the accepting edge.
- Reset asserted mid-operation discards all pending requests. The vector is empty at the next edge, regardless of flush_i or push_i.
- Boundary cases:
  - full + push only: rejected, err_ovf set, state holds.
  - full + push + pull: both accepted, count stays DEPTH.
  - count 1 + pull + push: both accepted, count stays 1.
  - empty + pull + push: only the push is accepted, count becomes 1, err_udf is set.
- No combinational path from the request inputs to valid_o, carry_o, last_o, empty_o, full_o or count_o.

## Test plan
- Reset, then DEPTH=4 with 4 consecutive pushes. Required: valid_o 0001, 0011, 0111, 1111 after the successive edges; full_o 1; count_o 4; carry_o 0111; last_o 0011.
- Full DEPTH=4 vector, push_i alone for 1 cycle. Required: push_o 0, err_ovf_o 1 next cycle, count_o stays 4. Then push_i + pull_i together. Required: push_o 1, pull_o 1, count_o 4, err_ovf_o stays 1 until clr_err_i.
- Empty vector, pull_i + push_i + set_i together. Required: pull_o 0, set_o 0, push_o 1; next cycle count_o 1, valid_o 0001, err_udf_o 1.
- count 3 (DEPTH=4), 3 pulls. Required: valid_o 0011, 0001, 0000 after the successive edges; empty_o 1. A 4th pull. Required: pull_o 0, err_udf_o 1.
- count 2, flush_i + push_i in the same cycle. Required: push_o 0, then count_o 0, empty_o 1, error flags unchanged.
- count 3, arst_i pulsed between edges during a push. Required: outputs return to reset values immediately, and count_o is 0 at the next edge.

Source files
------------

// File: rtl/status_value_ctrl.sv
// Occupancy and strobe controller for the status valid vector: qualifies raw
// push/pull/set requests and owns the thermometer valid mask, count and sticky errors.
module status_value_ctrl #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pull_i,
   input  logic             set_i,
   input  logic             clr_err_i,
   output logic             push_o,
   output logic             pull_o,
   output logic             set_o,
   output logic             update_o,
   output logic [DEPTH-1:0] valid_o,
   output logic [DEPTH-1:0] carry_o,
   output logic [DEPTH-1:0] last_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o,
   output logic             err_ovf_o,
   output logic             err_udf_o
);

   generate
      if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
         $error("status_value_ctrl: DEPTH must be in 2..64");
      end
   endgenerate

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_udf_q, err_udf_d;

   logic empty, full;
   logic push_ok, pull_ok, set_ok;

   // Occupancy flags come from registers only, so requests never reach them combinationally.
   assign empty = ~valid_q[0];
   assign full  = valid_q[DEPTH-1];

   // Zero-latency qualification; a push into a full vector needs a matching accepted pull.
   always_comb begin
      pull_ok = 1'b0;
      push_ok = 1'b0;
      set_ok  = 1'b0;
      if (!flush_i) begin
         pull_ok = pull_i & ~empty;
         push_ok = push_i & (~full | pull_ok);
         set_ok  = set_i & ~empty;
      end
   end

   // Next occupancy and sticky error state.
   always_comb begin
      valid_d   = valid_q;
      count_d   = count_q;
      err_ovf_d = err_ovf_q;
      err_udf_d = err_udf_q;

      if (flush_i) begin
         valid_d = '0;
         count_d = '0;
      end else begin
         unique case ({pull_ok, push_ok})
            2'b01: begin
               valid_d = {valid_q[DEPTH-2:0], 1'b1};
               count_d = count_q + CNT_W'(1);
            end
            2'b10: begin
               valid_d = valid_q >> 1;
               count_d = count_q - CNT_W'(1);
            end
            default: ;
         endcase
      end

      // Clear first so a same-cycle error event overrides it.
      if (clr_err_i) begin
         err_ovf_d = 1'b0;
         err_udf_d = 1'b0;
      end
      if (push_i & ~push_ok & ~flush_i) begin
         err_ovf_d = 1'b1;
      end
      if ((pull_i | set_i) & empty & ~flush_i) begin
         err_udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         valid_q   <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign push_o    = push_ok;
   assign pull_o    = pull_ok;
   assign set_o     = set_ok;
   assign update_o  = push_ok;
   assign valid_o   = valid_q;
   assign carry_o   = valid_q >> 1;
   assign last_o    = valid_q >> 2;
   assign empty_o   = empty;
   assign full_o    = full;
   assign count_o   = count_q;
   assign err_ovf_o = err_ovf_q;
   assign err_udf_o = err_udf_q;

   // Structural invariants of the occupancy state.
   a_thermo : assert property (@(posedge clk_i) disable iff (arst_i)
      (valid_q & (valid_q + DEPTH'(1))) == '0);
   a_count : assert property (@(posedge clk_i) disable iff (arst_i)
      CNT_W'($countones(valid_q)) == count_q);

endmodule

// File: tb/tb_status_value_ctrl.sv
// Bench for status_value_ctrl (DEPTH=4): directed vector table, hand-written
// async reset sequence and randomized traffic against a count-based reference.
module tb_status_value_ctrl;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             arst = 1'b1;
   logic             flush_i = 1'b0, push_i = 1'b0, pull_i = 1'b0, set_i = 1'b0, clr_err_i = 1'b0;
   logic             push_o, pull_o, set_o, update_o, empty_o, full_o, err_ovf_o, err_udf_o;
   logic [DEPTH-1:0] valid_o, carry_o, last_o;
   logic [CNT_W-1:0] count_o;

   status_value_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .arst_i(arst), .flush_i(flush_i), .push_i(push_i), .pull_i(pull_i),
      .set_i(set_i), .clr_err_i(clr_err_i), .push_o(push_o), .pull_o(pull_o),
      .set_o(set_o), .update_o(update_o), .valid_o(valid_o), .carry_o(carry_o),
      .last_o(last_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
      .err_ovf_o(err_ovf_o), .err_udf_o(err_udf_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference state: just an entry count and two sticky flags.
   int m_cnt = 0;
   bit m_ovf = 0, m_udf = 0;
   bit e_push, e_pull, e_set;

   typedef struct {
      bit fl, pu, pl, st, cl;
      bit x_push, x_pull, x_set;
      int x_cnt;
      bit x_ovf, x_udf;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DEPTH-1:0] therm(input int n);
      logic [DEPTH-1:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   // Expected strobes from the current reference count and the requests.
   task automatic model_strobes(input bit fl, input bit pu, input bit pl, input bit st);
      bit emp = (m_cnt == 0);
      bit ful = (m_cnt == DEPTH);
      e_pull = pl && !emp && !fl;
      e_push = pu && !fl && (!ful || e_pull);
      e_set  = st && !emp && !fl;
   endtask

   task automatic model_update(input bit fl, input bit pu, input bit pl, input bit st, input bit cl);
      bit emp = (m_cnt == 0);
      model_strobes(fl, pu, pl, st);
      if (cl) begin m_ovf = 0; m_udf = 0; end
      if (pu && !e_push && !fl) m_ovf = 1;
      if ((pl || st) && emp && !fl) m_udf = 1;
      if (fl) m_cnt = 0;
      else m_cnt = m_cnt + int'(e_push) - int'(e_pull);
   endtask

   task automatic check_state(input string tag, input int cnt, input bit ovf, input bit udf);
      logic [DEPTH-1:0] v = therm(cnt);
      check({tag, " count_o"}, 32'(count_o), 32'(cnt));
      check({tag, " valid_o"}, 32'(valid_o), 32'(v));
      check({tag, " carry_o"}, 32'(carry_o), 32'(v >> 1));
      check({tag, " last_o"},  32'(last_o),  32'(v >> 2));
      check({tag, " empty_o"}, 32'(empty_o), 32'(cnt == 0));
      check({tag, " full_o"},  32'(full_o),  32'(cnt == DEPTH));
      check({tag, " err_ovf_o"}, 32'(err_ovf_o), 32'(ovf));
      check({tag, " err_udf_o"}, 32'(err_udf_o), 32'(udf));
   endtask

   task automatic drive(input bit fl, input bit pu, input bit pl, input bit st, input bit cl);
      flush_i = fl; push_i = pu; pull_i = pl; set_i = st; clr_err_i = cl;
   endtask

   task automatic add(input bit fl, pu, pl, st, cl, xpu, xpl, xst, input int c, input bit o, u);
      vec_t t;
      t.fl = fl; t.pu = pu; t.pl = pl; t.st = st; t.cl = cl;
      t.x_push = xpu; t.x_pull = xpl; t.x_set = xst;
      t.x_cnt = c; t.x_ovf = o; t.x_udf = u;
      tbl.push_back(t);
   endtask

   initial begin
      //   fl pu pl st cl | push pull set | cnt ovf udf
      add(0, 1, 0, 0, 0,   1, 0, 0,   1, 0, 0);
      add(0, 1, 0, 0, 0,   1, 0, 0,   2, 0, 0);
      add(0, 1, 0, 0, 0,   1, 0, 0,   3, 0, 0);
      add(0, 1, 0, 0, 0,   1, 0, 0,   4, 0, 0);
      add(0, 1, 0, 0, 0,   0, 0, 0,   4, 1, 0);   // full + push: rejected
      add(0, 1, 1, 0, 0,   1, 1, 0,   4, 1, 0);   // full + push + pull
      add(0, 0, 0, 1, 0,   0, 0, 1,   4, 1, 0);   // set never moves occupancy
      add(0, 0, 1, 0, 0,   0, 1, 0,   3, 1, 0);
      add(0, 0, 1, 0, 0,   0, 1, 0,   2, 1, 0);
      add(1, 1, 0, 0, 0,   0, 0, 0,   0, 1, 0);   // flush beats push, errors kept
      add(0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 0);
      add(0, 1, 1, 1, 0,   1, 0, 0,   1, 0, 1);   // empty + pull + push + set
      add(0, 1, 0, 0, 0,   1, 0, 0,   2, 0, 1);
      add(0, 1, 0, 0, 0,   1, 0, 0,   3, 0, 1);
      add(0, 0, 1, 0, 0,   0, 1, 0,   2, 0, 1);
      add(0, 0, 1, 0, 0,   0, 1, 0,   1, 0, 1);
      add(0, 1, 1, 0, 0,   1, 1, 0,   1, 0, 1);   // count 1 + pull + push
      add(0, 0, 1, 0, 0,   0, 1, 0,   0, 0, 1);
      add(0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 1);   // pull while empty
      add(0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 0);
      add(0, 0, 0, 1, 1,   0, 0, 0,   0, 0, 1);   // set error wins over clear
      add(0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 0);

      // Reset state
      drive(0, 0, 0, 0, 0);
      #12;
      check_state("reset", 0, 0, 0);
      check("reset push_o", 32'(push_o), 32'd0);
      check("reset pull_o", 32'(pull_o), 32'd0);
      check("reset set_o", 32'(set_o), 32'd0);
      @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < tbl.size(); i++) begin
         vec_t t = tbl[i];
         drive(t.fl, t.pu, t.pl, t.st, t.cl);
         #1;
         check($sformatf("vec%0d push_o", i), 32'(push_o), 32'(t.x_push));
         check($sformatf("vec%0d pull_o", i), 32'(pull_o), 32'(t.x_pull));
         check($sformatf("vec%0d set_o", i), 32'(set_o), 32'(t.x_set));
         check($sformatf("vec%0d update_o", i), 32'(update_o), 32'(t.x_push));
         model_update(t.fl, t.pu, t.pl, t.st, t.cl);
         @(posedge clk); #1;
         check_state($sformatf("vec%0d", i), t.x_cnt, t.x_ovf, t.x_udf);
      end
      drive(0, 0, 0, 0, 0);

      // Async reset between edges while a push is pending at count 3
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         model_update(0, 1, 0, 0, 0);
         @(posedge clk); #1;
      end
      check_state("pre-arst", 3, m_ovf, m_udf);
      drive(0, 1, 0, 0, 0);
      #2;
      arst = 1'b1;
      #1;
      check_state("arst immediate", 0, 0, 0);
      @(posedge clk); #1;
      check_state("arst edge", 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      arst = 1'b0;
      m_cnt = 0; m_ovf = 0; m_udf = 0;
      @(posedge clk); #1;
      check_state("post-arst", 0, 0, 0);

      // Randomized traffic against the reference
      for (int i = 0; i < 400; i++) begin
         bit fl = ($urandom_range(0, 19) == 0);
         bit pu = ($urandom_range(0, 99) < 55);
         bit pl = ($urandom_range(0, 99) < 45);
         bit st = ($urandom_range(0, 3) == 0);
         bit cl = ($urandom_range(0, 15) == 0);
         drive(fl, pu, pl, st, cl);
         #1;
         model_strobes(fl, pu, pl, st);
         check("rnd push_o", 32'(push_o), 32'(e_push));
         check("rnd pull_o", 32'(pull_o), 32'(e_pull));
         check("rnd set_o", 32'(set_o), 32'(e_set));
         check("rnd update_o", 32'(update_o), 32'(e_push));
         model_update(fl, pu, pl, st, cl);
         @(posedge clk); #1;
         check_state("rnd", m_cnt, m_ovf, m_udf);
      end
      drive(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end
endmodule
